// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-channel TDM receive path.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serialized sample stream in, one registered frame of four channels out.
interface tdm_demux4_if #(parameter int W = 8) ();

  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_start;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic         frame_done;
  logic         sync_err;
  logic         locked;

  modport master (
    output din, din_valid, frame_start,
    input  y0, y1, y2, y3, frame_done, sync_err, locked
  );

  modport slave (
    input  din, din_valid, frame_start,
    output y0, y1, y2, y3, frame_done, sync_err, locked
  );

endinterface

// File: rtl/tdm_demux4_demux1x4.sv
// 1-to-4 slot decoder: one write enable per channel, gated by accept.
module demux1x4
  import tdm_pkg::*;
(
  input  slot_t             slot,
  input  logic              accept,
  output logic [NUM_CH-1:0] en
);

  always_comb begin
    en       = '0;
    en[slot] = accept;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: frame alignment FSM, shadow registers and
// atomic frame output.
//
// state | meaning
// HUNT  | unaligned, waiting for a frame_start sample
// TRACK | aligned, slot counter follows the incoming stream
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  tdm_demux4_if.slave     bus
);

  state_t            state_q;
  state_t            state_d;
  slot_t             slot_q;
  slot_t             eff_slot;
  logic              wr;
  logic              sync_err_d;
  logic [NUM_CH-1:0] wr_en;
  logic [W-1:0]      shadow [NUM_CH-1];
  logic [W-1:0]      y_q    [NUM_CH];
  logic              frame_done_q;
  logic              sync_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.din_valid) begin
      case (state_q)
        HUNT:    if (bus.frame_start) state_d = TRACK;
        TRACK:   if (!bus.frame_start && slot_q == '0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // A start-flagged sample always lands in slot 0, also when it arrives early.
  always_comb begin
    eff_slot   = bus.frame_start ? '0 : slot_q;
    wr         = 1'b0;
    sync_err_d = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: wr = bus.frame_start;
        TRACK: begin
          wr         = bus.frame_start || (slot_q != '0);
          sync_err_d = bus.frame_start ? (slot_q != '0) : (slot_q == '0);
        end
        default: wr = 1'b0;
      endcase
    end
  end

  demux1x4 u_demux (
    .slot   (eff_slot),
    .accept (wr),
    .en     (wr_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q       <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < NUM_CH - 1; i++) shadow[i] <= '0;
      for (int i = 0; i < NUM_CH; i++)     y_q[i]    <= '0;
    end else begin
      frame_done_q <= wr_en[NUM_CH-1];
      sync_err_q   <= sync_err_d;
      if (wr) slot_q <= eff_slot + 1'b1;
      for (int i = 0; i < NUM_CH - 1; i++) begin
        if (wr_en[i]) shadow[i] <= bus.din;
      end
      if (wr_en[NUM_CH-1]) begin
        y_q[0] <= shadow[0];
        y_q[1] <= shadow[1];
        y_q[2] <= shadow[2];
        y_q[3] <= bus.din;
      end
    end
  end

  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state_q == TRACK);

endmodule
